// File: rtl/mem1r2wx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem1r2wx_pkg
// Purpose  : Shared defaults and types for the two-write / one-read memory.
// Revision : 1.0  initial release
// ============================================================================
package mem1r2wx_pkg;

    // Default geometry of the merged-write memory
    localparam int ADDRBIT_DEF   = 9;
    localparam int DEPTH_DEF     = 512;
    localparam int WIDTH_DEF     = 32;
    localparam int PENDDEPTH_DEF = 4;

    // Pending port-2 write record at the default geometry. The queue keeps
    // the same {vld, addr, data} layout, resized to its own parameters.
    typedef struct packed {
        logic                   vld;
        logic [ADDRBIT_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0]   data;
    } pend_entry_t;

    // Source selected for the single physical array write each cycle
    typedef enum logic [1:0] {
        WSRC_NONE = 2'd0,   // no array write this cycle
        WSRC_P1   = 2'd1,   // port 1 direct write
        WSRC_PQ   = 2'd2,   // drained head of the pending queue
        WSRC_P2   = 2'd3    // port 2 direct write (queue empty, port 1 idle)
    } wsrc_e;

endpackage : mem1r2wx_pkg
`default_nettype wire

// File: rtl/mem1r2wx_pq.sv
`default_nettype none
// ============================================================================
// Module   : mem1r2wx_pq
// Purpose  : Pending queue for port-2 writes. Circular buffer with push/pop,
//            kill-by-address (clears valid on every matching entry) and a
//            youngest-match forward lookup over the occupied entries.
// Revision : 1.0  initial release
// ============================================================================
module mem1r2wx_pq
    import mem1r2wx_pkg::*;
#(
    parameter int ADDRBIT   = ADDRBIT_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int PENDDEPTH = PENDDEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    // push side (port 2 deferred writes)
    input  logic                         push_i,
    input  logic [ADDRBIT-1:0]           push_addr_i,
    input  logic [WIDTH-1:0]             push_data_i,
    // pop side (drain to the array)
    input  logic                         pop_i,
    // newer port-1 write invalidates older pending entries to the same address
    input  logic                         kill_i,
    input  logic [ADDRBIT-1:0]           kill_addr_i,
    // forward lookup for the read port
    input  logic [ADDRBIT-1:0]           look_addr_i,
    output logic                         hit_o,
    output logic [WIDTH-1:0]             fwd_data_o,
    // head entry
    output logic                         head_vld_o,
    output logic [ADDRBIT-1:0]           head_addr_o,
    output logic [WIDTH-1:0]             head_data_o,
    // status
    output logic [$clog2(PENDDEPTH):0]   cnt_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(PENDDEPTH);

    typedef struct packed {
        logic               vld;
        logic [ADDRBIT-1:0] addr;
        logic [WIDTH-1:0]   data;
    } entry_t;

    entry_t          ent_q [PENDDEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW:0]     cnt_q;
    logic [PW:0]     cnt_d;

    logic            w_full;
    logic            w_empty;
    logic            w_do_push;
    logic            w_do_pop;
    logic [PW-1:0]   w_slot;

    // Count is one bit wider than the pointers, so full and empty never alias
    assign w_full  = (cnt_q == (PW+1)'(PENDDEPTH));
    assign w_empty = (cnt_q == '0);

    // A push into a full queue is refused even when the head pops in the
    // same cycle: the caller has already flagged that write as dropped.
    assign w_do_push = push_i && !w_full;
    assign w_do_pop  = pop_i  && !w_empty;

    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign cnt_o       = cnt_q;
    assign head_vld_o  = ent_q[rd_ptr_q].vld;
    assign head_addr_o = ent_q[rd_ptr_q].addr;
    assign head_data_o = ent_q[rd_ptr_q].data;

    // Occupancy next state from accepted push/pop
    always_comb begin
        cnt_d = cnt_q;
        case ({w_do_push, w_do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all pending writes
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Entry storage: kills first, then the push, so a same-cycle push to the
    // killed address lands valid (port 2 is the newer write in that case)
    always_ff @(posedge clk) begin
        for (int i = 0; i < PENDDEPTH; i++) begin
            if (kill_i && (ent_q[i].addr == kill_addr_i)) begin
                ent_q[i].vld <= 1'b0;
            end
        end
        if (w_do_push) begin
            ent_q[wr_ptr_q] <= {1'b1, push_addr_i, push_data_i};
        end
    end

    // Youngest valid occupied entry matching the lookup address; walks from
    // head to tail so later (younger) matches override earlier ones
    always_comb begin
        hit_o      = 1'b0;
        fwd_data_o = '0;
        w_slot     = '0;
        for (int k = 0; k < PENDDEPTH; k++) begin
            w_slot = rd_ptr_q + PW'(k);
            if (((PW+1)'(k) < cnt_q) && ent_q[w_slot].vld &&
                (ent_q[w_slot].addr == look_addr_i)) begin
                hit_o      = 1'b1;
                fwd_data_o = ent_q[w_slot].data;
            end
        end
    end

endmodule : mem1r2wx_pq
`default_nettype wire

// File: rtl/mem1r2wx.sv
`default_nettype none
// ============================================================================
// Module   : mem1r2wx
// Purpose  : Two-write-port, one-read-port memory. Port 1 always writes the
//            array directly; port 2 writes directly when the array port is
//            free, else its write waits in a pending queue drained on idle
//            cycles. Reads forward the newest pending data.
// Revision : 1.0  initial release
// ============================================================================
module mem1r2wx
    import mem1r2wx_pkg::*;
#(
    parameter int ADDRBIT   = ADDRBIT_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int PENDDEPTH = PENDDEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    // port 1 (never stalled)
    input  logic [ADDRBIT-1:0]           wa1_i,
    input  logic                         we1_i,
    input  logic [WIDTH-1:0]             di1_i,
    // port 2 (direct or deferred)
    input  logic [ADDRBIT-1:0]           wa2_i,
    input  logic                         we2_i,
    input  logic [WIDTH-1:0]             di2_i,
    output logic                         full2_o,
    output logic                         ovf2_o,
    output logic [$clog2(PENDDEPTH):0]   pcnt_o,
    // read port, one cycle latency
    input  logic [ADDRBIT-1:0]           ra_i,
    output logic [WIDTH-1:0]             do_o
);

    localparam int PW = $clog2(PENDDEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   do_q;
    logic               ovf2_q;

    wsrc_e              w_src;
    logic               w_push;
    logic               w_pop;
    logic               w_mem_we;
    logic [ADDRBIT-1:0] w_mem_addr;
    logic [WIDTH-1:0]   w_mem_data;

    logic               w_full;
    logic               w_empty;
    logic [PW:0]        w_cnt;
    logic               w_head_vld;
    logic [ADDRBIT-1:0] w_head_addr;
    logic [WIDTH-1:0]   w_head_data;
    logic               w_hit;
    logic [WIDTH-1:0]   w_fwd_data;

    mem1r2wx_pq #(
        .ADDRBIT   (ADDRBIT),
        .WIDTH     (WIDTH),
        .PENDDEPTH (PENDDEPTH)
    ) u_pq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_addr_i (wa2_i),
        .push_data_i (di2_i),
        .pop_i       (w_pop),
        .kill_i      (w_src == WSRC_P1),
        .kill_addr_i (wa1_i),
        .look_addr_i (ra_i),
        .hit_o       (w_hit),
        .fwd_data_o  (w_fwd_data),
        .head_vld_o  (w_head_vld),
        .head_addr_o (w_head_addr),
        .head_data_o (w_head_data),
        .cnt_o       (w_cnt),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    assign full2_o = w_full;
    assign ovf2_o  = ovf2_q;
    assign pcnt_o  = w_cnt;
    assign do_o    = do_q;

    // Array-port arbitration: port 1, then queue drain, then port 2 direct.
    // Nothing is written or drained while reset is asserted, so pending
    // entries never leak into the array across a reset.
    always_comb begin
        w_src  = WSRC_NONE;
        w_push = 1'b0;
        w_pop  = 1'b0;
        if (!rst) begin
            if (we1_i) begin
                w_src  = WSRC_P1;
                w_push = we2_i && !w_full;
            end else if (!w_empty) begin
                w_pop  = 1'b1;
                w_src  = w_head_vld ? WSRC_PQ : WSRC_NONE;
                w_push = we2_i && !w_full;
            end else if (we2_i) begin
                w_src  = WSRC_P2;
            end
        end
    end

    // Write-port data mux driven by the selected source
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        w_mem_data = '0;
        case (w_src)
            WSRC_P1: begin
                w_mem_we   = 1'b1;
                w_mem_addr = wa1_i;
                w_mem_data = di1_i;
            end
            WSRC_PQ: begin
                w_mem_we   = 1'b1;
                w_mem_addr = w_head_addr;
                w_mem_data = w_head_data;
            end
            WSRC_P2: begin
                w_mem_we   = 1'b1;
                w_mem_addr = wa2_i;
                w_mem_data = di2_i;
            end
            default: begin
                w_mem_we   = 1'b0;
            end
        endcase
    end

    // Storage array: not reset, contents persist across reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read: pending data wins over the array (read-old semantics,
    // both the array and the queue are sampled before this cycle's updates)
    always_ff @(posedge clk) begin
        if (rst) begin
            do_q <= '0;
        end else begin
            do_q <= w_hit ? w_fwd_data : mem_q[ra_i];
        end
    end

    // One-cycle pulse for a port-2 write refused because the queue was full
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf2_q <= 1'b0;
        end else begin
            ovf2_q <= we2_i && w_full;
        end
    end

endmodule : mem1r2wx
`default_nettype wire

// File: tb/tb_mem1r2wx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem1r2wx
// Purpose  : Directed self-checking bench for mem1r2wx.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem1r2wx;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int PD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wa1, wa2, ra;
    logic          we1, we2;
    logic [DW-1:0] di1, di2, dout;
    logic          full2, ovf2;
    logic [2:0]    pcnt;

    int n_cmp = 0;
    int n_err = 0;

    mem1r2wx #(
        .ADDRBIT   (AW),
        .DEPTH     (512),
        .WIDTH     (DW),
        .PENDDEPTH (PD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wa1_i  (wa1),
        .we1_i  (we1),
        .di1_i  (di1),
        .wa2_i  (wa2),
        .we2_i  (we2),
        .di2_i  (di2),
        .full2_o(full2),
        .ovf2_o (ovf2),
        .pcnt_o (pcnt),
        .ra_i   (ra),
        .do_o   (dout)
    );

    always #5 clk = ~clk;

    // advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we1 = 1'b0;
        we2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); ra = '0; wa1 = '0; wa2 = '0; di1 = '0; di2 = '0;
        step(); step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL reset_pcnt: got %0d want 0", pcnt); end
        n_cmp++; if (full2 !== 1'b0) begin n_err++; $display("FAIL reset_full2: got %b want 0", full2); end
        n_cmp++; if (ovf2 !== 1'b0) begin n_err++; $display("FAIL reset_ovf2: got %b want 0", ovf2); end
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_do: got %h want 0", dout); end
        rst = 1'b0;
    endtask

    task automatic test_solo();
        we1 = 1'b1; wa1 = 9'd5; di1 = 32'hAA; step();
        we1 = 1'b0; we2 = 1'b1; wa2 = 9'd6; di2 = 32'hBB; step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL solo_pcnt_p2: got %0d want 0", pcnt); end
        idle(); ra = 9'd5; step();
        n_cmp++; if (dout !== 32'hAA) begin n_err++; $display("FAIL solo_rd5: got %h want aa", dout); end
        ra = 9'd6; step();
        n_cmp++; if (dout !== 32'hBB) begin n_err++; $display("FAIL solo_rd6: got %h want bb", dout); end
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL solo_pcnt_end: got %0d want 0", pcnt); end
    endtask

    task automatic test_collision();
        we1 = 1'b1; wa1 = 9'd1; di1 = 32'h11; we2 = 1'b1; wa2 = 9'd2; di2 = 32'h22; step();
        n_cmp++; if (pcnt !== 3'd1) begin n_err++; $display("FAIL coll_pcnt1: got %0d want 1", pcnt); end
        // idle drain cycle; the read of 2 sees the entry being popped
        idle(); ra = 9'd2; step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL coll_pcnt0: got %0d want 0", pcnt); end
        n_cmp++; if (dout !== 32'h22) begin n_err++; $display("FAIL coll_fwd_pop: got %h want 22", dout); end
        ra = 9'd2; step();
        n_cmp++; if (dout !== 32'h22) begin n_err++; $display("FAIL coll_rd_arr: got %h want 22", dout); end
        // second collision: read in the push cycle is read-old
        we1 = 1'b1; wa1 = 9'd1; di1 = 32'h13; we2 = 1'b1; wa2 = 9'd2; di2 = 32'h23; ra = 9'd2; step();
        n_cmp++; if (dout !== 32'h22) begin n_err++; $display("FAIL coll_rd_old: got %h want 22", dout); end
        n_cmp++; if (pcnt !== 3'd1) begin n_err++; $display("FAIL coll2_pcnt: got %0d want 1", pcnt); end
        idle(); ra = 9'd2; step();
        n_cmp++; if (dout !== 32'h23) begin n_err++; $display("FAIL coll_fwd_pend: got %h want 23", dout); end
        ra = 9'd1; step();
        n_cmp++; if (dout !== 32'h13) begin n_err++; $display("FAIL coll_rd1: got %h want 13", dout); end
    endtask

    task automatic test_same_addr();
        we1 = 1'b1; wa1 = 9'd3; di1 = 32'h01; we2 = 1'b1; wa2 = 9'd3; di2 = 32'h02; step();
        n_cmp++; if (pcnt !== 3'd1) begin n_err++; $display("FAIL same_pcnt1: got %0d want 1", pcnt); end
        idle(); step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL same_drain: got %0d want 0", pcnt); end
        ra = 9'd3; step();
        n_cmp++; if (dout !== 32'h02) begin n_err++; $display("FAIL same_p2_wins: got %h want 02", dout); end
        we1 = 1'b1; wa1 = 9'd7; di1 = 32'h70; we2 = 1'b1; wa2 = 9'd3; di2 = 32'h03; step();
        n_cmp++; if (pcnt !== 3'd1) begin n_err++; $display("FAIL kill_push: got %0d want 1", pcnt); end
        we1 = 1'b1; wa1 = 9'd3; di1 = 32'h04; we2 = 1'b0; step();
        n_cmp++; if (pcnt !== 3'd1) begin n_err++; $display("FAIL kill_counted: got %0d want 1", pcnt); end
        idle(); ra = 9'd3; step();
        n_cmp++; if (dout !== 32'h04) begin n_err++; $display("FAIL kill_no_fwd: got %h want 04", dout); end
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL kill_popped: got %0d want 0", pcnt); end
        ra = 9'd3; step();
        n_cmp++; if (dout !== 32'h04) begin n_err++; $display("FAIL kill_no_write: got %h want 04", dout); end
        ra = 9'd7; step();
        n_cmp++; if (dout !== 32'h70) begin n_err++; $display("FAIL kill_rd7: got %h want 70", dout); end
    endtask

    task automatic test_overflow();
        we1 = 1'b1; wa1 = 9'h24; di1 = 32'hDEAD; step();
        for (int i = 0; i < 4; i++) begin
            we1 = 1'b1; wa1 = AW'(9'h10 + i); di1 = DW'(32'h100 + i);
            we2 = 1'b1; wa2 = AW'(9'h20 + i); di2 = DW'(32'h200 + i);
            step();
        end
        n_cmp++; if (pcnt !== 3'd4) begin n_err++; $display("FAIL ovf_pcnt4: got %0d want 4", pcnt); end
        n_cmp++; if (full2 !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full2); end
        n_cmp++; if (ovf2 !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", ovf2); end
        we1 = 1'b1; wa1 = 9'h14; di1 = 32'h104; we2 = 1'b1; wa2 = 9'h24; di2 = 32'h204; step();
        n_cmp++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", ovf2); end
        n_cmp++; if (pcnt !== 3'd4) begin n_err++; $display("FAIL ovf_pcnt_hold: got %0d want 4", pcnt); end
        idle(); step();
        n_cmp++; if (ovf2 !== 1'b0) begin n_err++; $display("FAIL ovf_one_cycle: got %b want 0", ovf2); end
        n_cmp++; if (pcnt !== 3'd3) begin n_err++; $display("FAIL ovf_drain1: got %0d want 3", pcnt); end
        n_cmp++; if (full2 !== 1'b0) begin n_err++; $display("FAIL ovf_notfull: got %b want 0", full2); end
        step(); step(); step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL ovf_drained: got %0d want 0", pcnt); end
        for (int i = 0; i < 5; i++) begin
            ra = AW'(9'h20 + i); step();
            n_cmp++;
            if (dout !== ((i < 4) ? DW'(32'h200 + i) : 32'hDEAD)) begin
                n_err++; $display("FAIL ovf_rd_%0d: got %h want %h", i, dout, (i < 4) ? DW'(32'h200 + i) : 32'hDEAD);
            end
        end
        ra = 9'h14; step();
        n_cmp++; if (dout !== 32'h104) begin n_err++; $display("FAIL ovf_rd_p1: got %h want 104", dout); end
    endtask

    task automatic test_full_pushpop();
        we1 = 1'b1; wa1 = 9'h44; di1 = 32'hBEEF; step();
        for (int i = 0; i < 4; i++) begin
            we1 = 1'b1; wa1 = AW'(9'h30 + i); di1 = DW'(32'h300 + i);
            we2 = 1'b1; wa2 = AW'(9'h40 + i); di2 = DW'(32'h400 + i);
            step();
        end
        n_cmp++; if (full2 !== 1'b1) begin n_err++; $display("FAIL pp_full: got %b want 1", full2); end
        // pop and refused push in the same cycle
        we1 = 1'b0; we2 = 1'b1; wa2 = 9'h44; di2 = 32'h444; step();
        n_cmp++; if (ovf2 !== 1'b1) begin n_err++; $display("FAIL pp_ovf: got %b want 1", ovf2); end
        n_cmp++; if (pcnt !== 3'd3) begin n_err++; $display("FAIL pp_pcnt: got %0d want 3", pcnt); end
        idle(); step(); step(); step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL pp_drained: got %0d want 0", pcnt); end
        ra = 9'h44; step();
        n_cmp++; if (dout !== 32'hBEEF) begin n_err++; $display("FAIL pp_dropped: got %h want beef", dout); end
        ra = 9'h43; step();
        n_cmp++; if (dout !== 32'h403) begin n_err++; $display("FAIL pp_rd43: got %h want 403", dout); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            we1 = 1'b1; wa1 = AW'(9'h50 + i); di1 = DW'(32'h500 + i); step();
        end
        for (int i = 0; i < 3; i++) begin
            we1 = 1'b1; wa1 = AW'(9'h60 + i); di1 = DW'(32'h600 + i);
            we2 = 1'b1; wa2 = AW'(9'h50 + i); di2 = DW'(32'h5A0 + i);
            ra  = 9'h50;
            step();
        end
        n_cmp++; if (pcnt !== 3'd3) begin n_err++; $display("FAIL rm_pcnt3: got %0d want 3", pcnt); end
        n_cmp++; if (dout !== 32'h5A0) begin n_err++; $display("FAIL rm_fwd: got %h want 5a0", dout); end
        rst = 1'b1; idle(); step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL rm_pcnt0: got %0d want 0", pcnt); end
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL rm_do0: got %h want 0", dout); end
        rst = 1'b0; step(); step();
        n_cmp++; if (pcnt !== 3'd0) begin n_err++; $display("FAIL rm_stay0: got %0d want 0", pcnt); end
        for (int i = 0; i < 3; i++) begin
            ra = AW'(9'h50 + i); step();
            n_cmp++;
            if (dout !== DW'(32'h500 + i)) begin
                n_err++; $display("FAIL rm_old_%0d: got %h want %h", i, dout, DW'(32'h500 + i));
            end
        end
        ra = 9'h62; step();
        n_cmp++; if (dout !== 32'h602) begin n_err++; $display("FAIL rm_p1_kept: got %h want 602", dout); end
    endtask

    initial begin
        test_reset();
        test_solo();
        test_collision();
        test_same_addr();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem1r2wx
`default_nettype wire
